pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage core. It replaces the hand-written per-boundary registers such as the decode-to-execute register with one configurable block. It carries an opaque payload of DATA_W bits plus a valid bit, and takes its hold/bubble decision from its own pair of bits in the global stall vector. It adds a flush input, a valid bit and optional stall/bubble performance counters. One instance sits at each stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- DATA_W, 64: payload width in bits; range 1..512.
- NOP_VAL, {DATA_W{1'b0}}: payload loaded on reset, flush and bubble. Encodes the NOP op, select, zero operands, NOP register address and write disable.
- STAGE, 2: index of this register's upstream stage in the stall vector; range 0..STALL_W-2.
- STALL_W, 6: stall vector width.
- CNT_W, 32: performance counter width; used only when PIPE_REG_PERF_EN is defined.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset: 0 resets on the next clk edge, 1 runs.
- stall  in  STALL_W  global stall vector; bit i = 1 (STOP) means stage i is stalled.
- flush  in  1  exception/branch-kill flush; highest priority after reset.
- in_data  in  DATA_W  payload from the upstream stage.
- in_valid  in  1  upstream payload is a real instruction.
- out_data  out  DATA_W  registered payload to the downstream stage.
- out_valid  out  1  registered valid.
- perf_clr  in  1  synchronous counter clear; present only with PIPE_REG_PERF_EN.
- bubble_cnt  out  CNT_W  number of bubbles inserted; present only with PIPE_REG_PERF_EN.
- hold_cnt  out  CNT_W  number of cycles held; present only with PIPE_REG_PERF_EN.

## Operation
- Let up = stall[STAGE] and dn = stall[STAGE+1]. Each cycle exactly one action applies, first match wins:
  1. RESET (rst = 0): out_data = NOP_VAL, out_valid = 0; counters = 0.
  2. FLUSH (flush = 1): out_data = NOP_VAL, out_valid = 0.
  3. BUBBLE (up = 1, dn = 0): out_data = NOP_VAL, out_valid = 0; bubble_cnt increments.
  4. CAPTURE (up = 0): out_data = in_data, out_valid = in_valid.
  5. HOLD (up = 1, dn = 1): outputs unchanged; hold_cnt increments.
- Combinations:
  - flush together with a stall still loads NOP; no counter increments.
  - up = 0 with dn = 1 is a malformed stall vector, because the controller asserts stall bits contiguously from bit 0. The block still performs CAPTURE. The bench flags this combination as an assertion error.
- Datapath: payload is opaque. No arithmetic on it. There is no combinational path from any input to out_data or out_valid.
- Counters:
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - perf_clr has priority over increment.
  - Reset clears both counters.

## Timing
- Latency: 1 cycle. in_data sampled at edge N appears on out_data after edge N.
- A bubble occupies exactly one cycle per cycle of (up = 1, dn = 0). Asserting up for k cycles with dn = 0 yields k consecutive NOP cycles.
- Reset mid-HOLD or mid-BUBBLE: NOP and valid 0 appear after the first edge with rst = 0. Normal operation resumes on the first edge with rst = 1.
- Reset values: out_data = NOP_VAL, out_valid = 0, bubble_cnt = 0, hold_cnt = 0.

## Configuration
- PIPE_REG_PERF_EN defined: perf_clr, bubble_cnt and hold_cnt ports and the counter logic exist.
- PIPE_REG_PERF_EN undefined: those ports and the counter logic are absent. Register behaviour is identical in both builds.

## Structure
- Shared constants go in defines.v, not in this block:
  - STOP / NO_STOP values.
  - Stage index constants: STG_IF = 1, STG_ID = 2, STG_EX = 3, STG_MEM = 4.
  - Per-boundary payload widths.
  - Packed NOP values for each boundary.
- Sub-module pipe_perf_cnt: one saturating counter with clr and inc inputs. It is instantiated twice under PIPE_REG_PERF_EN.
- Top level of the block: a priority decode of the five actions plus the payload and valid registers.

## Test plan
- Reset: rst = 0 for 2 cycles with in_data = 64'hDEAD_BEEF_0000_0001 and in_valid = 1 → out_data = NOP_VAL (0), out_valid = 0, both counters 0.
- Capture stream: stall = 6'b000000, in_data = 1, 2, 3 on successive cycles → out_data = 1, 2, 3 each one cycle later, out_valid = 1.
- Load-use bubble at STAGE = 2: stall = 6'b000111 for 1 cycle with in_data = 5 → next out_data = NOP_VAL, out_valid = 0, bubble_cnt = 1. Then stall = 0 with in_data = 5 → out_data = 5.
- Hold: out_data = 7, then stall = 6'b001111 for 3 cycles with in_data changing to 8, 9, 10 → out_data stays 7, hold_cnt = 3.
- Flush priority: stall = 6'b001111 and flush = 1 → out_data = NOP_VAL, out_valid = 0, hold_cnt unchanged.
- Saturation with CNT_W = 4: 20 bubble cycles → bubble_cnt = 15. perf_clr = 1 together with a bubble → bubble_cnt = 0.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the inter-stage pipeline register: the per-cycle action
// enumeration and the priority decode that selects exactly one action.
package pipe_stage_reg_pkg;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_CAPTURE,
        ACT_HOLD
    } stage_act_e;

    // First match wins. An upstream run with a stalled downstream (up=0, dn=1)
    // can't come from a well-formed stall controller but still captures.
    function automatic stage_act_e decode_action(
        input logic rst,
        input logic flush,
        input logic up,
        input logic dn
    );
        if (!rst)
            return ACT_RESET;
        else if (flush)
            return ACT_FLUSH;
        else if (up && !dn)
            return ACT_BUBBLE;
        else if (!up)
            return ACT_CAPTURE;
        else
            return ACT_HOLD;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Payload/valid bus crossing one pipeline boundary. The master side is the
// upstream stage (drives in_*), the slave side is the pipeline register.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;

    modport master (
        output in_data,
        output in_valid,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/pipe_stage_reg_perf_cnt.sv
// pipe_perf_cnt: one saturating performance counter with synchronous clear.
// Clear beats increment; the counter sticks at all-ones instead of wrapping.
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline boundary register with flush, bubble
// and hold. Define PIPE_REG_PERF_EN to add the bubble/hold counters.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W  = 64,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter int                STAGE   = 2,
    parameter int                STALL_W = 6
`ifdef PIPE_REG_PERF_EN
    ,
    parameter int                CNT_W   = 32
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
`ifdef PIPE_REG_PERF_EN
    input  logic               perf_clr,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt,
`endif
    pipe_stage_reg_if.slave    bus
);

    logic              up;
    logic              dn;
    stage_act_e        action;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              unused_stall;

    assign up           = stall[STAGE];
    assign dn           = stall[STAGE+1];
    assign unused_stall = ^stall;

    always_comb begin
        action = decode_action(rst, flush, up, dn);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q  <= NOP_VAL;
            valid_q <= 1'b0;
        end else begin
            case (action)
                ACT_FLUSH, ACT_BUBBLE: begin
                    data_q  <= NOP_VAL;
                    valid_q <= 1'b0;
                end
                ACT_CAPTURE: begin
                    data_q  <= bus.in_data;
                    valid_q <= bus.in_valid;
                end
                default: begin
                    data_q  <= data_q;
                    valid_q <= valid_q;
                end
            endcase
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;

`ifdef PIPE_REG_PERF_EN
    // Flush suppresses both increments because it wins the action decode.
    logic bubble_inc;
    logic hold_inc;

    assign bubble_inc = (action == ACT_BUBBLE);
    assign hold_inc   = (action == ACT_HOLD);

    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (hold_inc),
        .count (hold_cnt)
    );
`endif

endmodule
